// File: rtl/ports_bus_responder.sv
// ports_bus_responder: responder end of a half-duplex single-beat register bus.
// Writes land in a small register file; reads wait TURN idle cycles and then
// drive the shared data bus for exactly one cycle together with ack.
// Optional parity on the shared bus: define PORTS_BUS_RESPONDER_PARITY_EN.
module ports_bus_responder #(
  parameter int DW   = 8,
  parameter int AW   = 2,
  parameter int TURN = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  inout  wire  [DW-1:0] data,
`ifdef PORTS_BUS_RESPONDER_PARITY_EN
  inout  wire           par,
`endif
  output logic          ack,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WACK  = 2'd1,
    ST_TURN  = 2'd2,
    ST_DRIVE = 2'd3
  } state_t;

  localparam int DEPTH = 2 ** AW;

  state_t          state_q;
  logic [1:0]      cnt_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   rdata_q;
  logic            drive_q;
  logic            ack_q;
  logic            busy_q;
  logic            err_q;
  logic [DW-1:0]   mem_q [DEPTH];
  logic            drive_en_s;
  logic            wr_ok_s;

  // Parity of a register word, used both for checking writes and driving reads.
  function automatic logic word_parity(input logic [DW-1:0] w);
    return ^w;
  endfunction

`ifdef PORTS_BUS_RESPONDER_PARITY_EN
  logic par_q;

  // A write is accepted only when the initiator's even parity matches the data.
  always_comb begin
    wr_ok_s = 1'b1;
    if (par != word_parity(data)) begin
      wr_ok_s = 1'b0;
    end else begin
      wr_ok_s = 1'b1;
    end
  end

  assign par = drive_en_s ? par_q : 1'bz;
`else
  assign wr_ok_s = 1'b1;
`endif

  // Reset releases the bus immediately, even in the middle of a DRIVE cycle.
  assign drive_en_s = drive_q && !rst;
  assign data       = drive_en_s ? rdata_q : {DW{1'bz}};

  assign ack  = ack_q;
  assign busy = busy_q;
  assign err  = err_q;

  // Protocol FSM with registered strobes, bus-drive enable and register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= {AW{1'b0}};
      rdata_q <= {DW{1'b0}};
      drive_q <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef PORTS_BUS_RESPONDER_PARITY_EN
      par_q   <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
    end else begin
      ack_q   <= 1'b0;
      drive_q <= 1'b0;
      // Any request while a transaction is in flight is dropped and flagged.
      if (req && busy_q) begin
        err_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            busy_q <= 1'b1;
            if (we) begin
              // Rejected parity writes still complete with ack.
              if (wr_ok_s) begin
                mem_q[addr] <= data;
              end else begin
                err_q <= 1'b1;
              end
              state_q <= ST_WACK;
              ack_q   <= 1'b1;
            end else begin
              addr_q <= addr;
              if (TURN == 0) begin
                state_q <= ST_DRIVE;
                ack_q   <= 1'b1;
                drive_q <= 1'b1;
                rdata_q <= mem_q[addr];
`ifdef PORTS_BUS_RESPONDER_PARITY_EN
                par_q   <= word_parity(mem_q[addr]);
`endif
              end else begin
                state_q <= ST_TURN;
                cnt_q   <= 2'(TURN - 1);
              end
            end
          end
        end
        ST_WACK: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        ST_TURN: begin
          // Memory cannot change while busy, so sampling it here is safe.
          if (cnt_q == 2'd0) begin
            state_q <= ST_DRIVE;
            ack_q   <= 1'b1;
            drive_q <= 1'b1;
            rdata_q <= mem_q[addr_q];
`ifdef PORTS_BUS_RESPONDER_PARITY_EN
            par_q   <= word_parity(mem_q[addr_q]);
`endif
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        ST_DRIVE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ports_bus_responder.sv
// Directed bench for ports_bus_responder. The shared bus is pulled up, so a
// released bus reads as all ones; read data used here is never 8'hFF.
module tb_ports_bus_responder #(
  parameter int TURN = 1
);

  localparam int DW = 8;
  localparam int AW = 2;
  localparam logic [DW-1:0] REL = 8'hFF;

  logic          clk;
  logic          rst;
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic          ack;
  logic          busy;
  logic          err;
  logic          drv_en;
  logic [DW-1:0] drv_val;
  wire  [DW-1:0] data_w;

  int total;
  int bad;

  pullup (data_w);
  assign data_w = drv_en ? drv_val : 8'bzzzzzzzz;

`ifdef PORTS_BUS_RESPONDER_PARITY_EN
  wire  par_w;
  logic par_flip;
  logic par_drv;
  pullup (par_w);
  assign par_w = drv_en ? par_drv : 1'bz;
`endif

  ports_bus_responder #(.DW(DW), .AW(AW), .TURN(TURN)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .we   (we),
    .addr (addr),
    .data (data_w),
`ifdef PORTS_BUS_RESPONDER_PARITY_EN
    .par  (par_w),
`endif
    .ack  (ack),
    .busy (busy),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write: req in cycle 0, ack in cycle 1, idle again in cycle 2.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] v);
    req = 1'b1; we = 1'b1; addr = a; drv_en = 1'b1; drv_val = v;
`ifdef PORTS_BUS_RESPONDER_PARITY_EN
    par_drv = (^v) ^ par_flip;
`endif
    step();
    req = 1'b0; drv_en = 1'b0; #1;
    chk("wr_ack", {31'd0, ack}, 32'd1);
    chk("wr_busy", {31'd0, busy}, 32'd1);
    chk("wr_nodrive", {24'd0, data_w}, {24'd0, REL});
    step();
    chk("wr_ack_low", {31'd0, ack}, 32'd0);
    chk("wr_idle", {31'd0, busy}, 32'd0);
  endtask

  // Read: bus released in cycles 0..TURN, driven with ack in cycle TURN+1.
  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    req = 1'b1; we = 1'b0; addr = a; #1;
    chk("rd_req_z", {24'd0, data_w}, {24'd0, REL});
    step();
    req = 1'b0;
    for (int k = 1; k <= TURN; k++) begin
      chk("rd_turn_ack", {31'd0, ack}, 32'd0);
      chk("rd_turn_busy", {31'd0, busy}, 32'd1);
      chk("rd_turn_z", {24'd0, data_w}, {24'd0, REL});
      step();
    end
    chk("rd_ack", {31'd0, ack}, 32'd1);
    chk("rd_data", {24'd0, data_w}, {24'd0, exp});
`ifdef PORTS_BUS_RESPONDER_PARITY_EN
    chk("rd_par", {31'd0, par_w}, {31'd0, ^exp});
`endif
    step();
    chk("rd_ack_low", {31'd0, ack}, 32'd0);
    chk("rd_idle", {31'd0, busy}, 32'd0);
    chk("rd_release", {24'd0, data_w}, {24'd0, REL});
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 2'd0;
    drv_en = 1'b0; drv_val = 8'h00;
`ifdef PORTS_BUS_RESPONDER_PARITY_EN
    par_flip = 1'b0; par_drv = 1'b0;
`endif
    // Reset for two cycles.
    step(); step();
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_data_z", {24'd0, data_w}, {24'd0, REL});
    rst = 1'b0;

    // Reset then read.
    do_read(2'd3, 8'h00);
    chk("rd_err0", {31'd0, err}, 32'd0);

    // Write / read back, other addresses untouched.
    do_write(2'd1, 8'hA5);
    do_read(2'd1, 8'hA5);
    do_read(2'd0, 8'h00);
    do_read(2'd2, 8'h00);
    do_read(2'd3, 8'h00);
    chk("b2b_err0", {31'd0, err}, 32'd0);

    // Collision: second request during the write ack cycle is dropped.
    req = 1'b1; we = 1'b1; addr = 2'd2; drv_en = 1'b1; drv_val = 8'h3C;
    step();
    chk("col_ack", {31'd0, ack}, 32'd1);
    chk("col_err_pre", {31'd0, err}, 32'd0);
    drv_val = 8'hC3;
    step();
    req = 1'b0; drv_en = 1'b0;
    chk("col_err", {31'd0, err}, 32'd1);
    chk("col_ack_low", {31'd0, ack}, 32'd0);
    chk("col_busy", {31'd0, busy}, 32'd0);
    do_read(2'd2, 8'h3C);
    chk("col_err_sticky", {31'd0, err}, 32'd1);

    // Reset clears err and the register file.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_err", {31'd0, err}, 32'd0);
    do_read(2'd1, 8'h00);

    // Reset in the cycle after a read request abandons the read.
    do_write(2'd1, 8'h5A);
    req = 1'b1; we = 1'b0; addr = 2'd1;
    step();
    req = 1'b0; rst = 1'b1; #1;
    chk("mid_rst_z", {24'd0, data_w}, {24'd0, REL});
    step();
    rst = 1'b0;
    chk("mid_rst_ack", {31'd0, ack}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_data", {24'd0, data_w}, {24'd0, REL});
    step();
    chk("mid_rst_noack", {31'd0, ack}, 32'd0);
    do_read(2'd1, 8'h00);
    chk("mid_rst_err", {31'd0, err}, 32'd0);

`ifdef PORTS_BUS_RESPONDER_PARITY_EN
    // Bad parity: acked, flagged, memory unchanged.
    par_flip = 1'b1;
    do_write(2'd3, 8'h03);
    par_flip = 1'b0;
    chk("par_bad_err", {31'd0, err}, 32'd1);
    do_read(2'd3, 8'h00);
    // Good parity: stored, read returns matching parity.
    do_write(2'd3, 8'h03);
    do_read(2'd3, 8'h03);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
